// File: rtl/snn_aer_pkg.sv
// Shared types and helpers for the spike-to-AER encoder slice.
package snn_aer_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } aer_state_e;

    // Event address width for an n-neuron layer (never narrower than one bit).
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lsb_priority_enc.sv
// Combinational lowest-set-bit priority encoder with any-set and single-bit flags.
module lsb_priority_enc #(
    parameter int N = 64,
    parameter int W = 6
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any,
    output logic         single
);

    logic [N-1:0] vec_minus_one_s;

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = {W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
            end else begin
                idx = idx;
            end
        end
    end

    // Flags: any bit set, and exactly one bit set.
    always_comb begin
        vec_minus_one_s = vec - {{(N-1){1'b0}}, 1'b1};
        any             = (vec != {N{1'b0}});
        single          = ((vec & vec_minus_one_s) == {N{1'b0}}) && any;
    end

endmodule

// File: rtl/spike_aer_encoder.sv
// Serialises a captured spike frame into ascending AER events over valid/ready.
// Optional macro SPIKE_AER_COUNT_EN adds the frame_spike_cnt popcount output.
module spike_aer_encoder
    import snn_aer_pkg::*;
#(
    parameter int NEURON_NUM = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ce,
    input  logic [NEURON_NUM-1:0]           spike_in,
    input  logic                            frame_valid,
    output logic                            frame_ready,
    output logic                            aer_valid,
    input  logic                            aer_ready,
    output logic [addr_w(NEURON_NUM)-1:0]   aer_addr,
    output logic                            aer_last,
`ifdef SPIKE_AER_COUNT_EN
    output logic [addr_w(NEURON_NUM):0]     frame_spike_cnt,
`endif
    output logic                            busy
);

    localparam int ADDR_W = addr_w(NEURON_NUM);

    aer_state_e              state_r;
    aer_state_e              state_nxt_s;
    logic [NEURON_NUM-1:0]   pending_r;
    logic [NEURON_NUM-1:0]   pending_nxt_s;
    logic [ADDR_W-1:0]       idx_s;
    logic                    any_s;
    logic                    single_s;
    logic                    capture_s;

    // Outputs are registered from the encoding of next-state pending, so the
    // event seen this cycle always describes pending_r with no input path.
    lsb_priority_enc #(
        .N (NEURON_NUM),
        .W (ADDR_W)
    ) u_enc (
        .vec    (pending_nxt_s),
        .idx    (idx_s),
        .any    (any_s),
        .single (single_s)
    );

    // Next-state and next-pending decode.
    always_comb begin
        state_nxt_s   = state_r;
        pending_nxt_s = pending_r;
        capture_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (frame_valid && ce) begin
                    capture_s     = 1'b1;
                    pending_nxt_s = spike_in;
                    if (spike_in != {NEURON_NUM{1'b0}}) begin
                        state_nxt_s = SCAN;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SCAN: begin
                if (aer_ready) begin
                    pending_nxt_s = pending_r & (pending_r - {{(NEURON_NUM-1){1'b0}}, 1'b1});
                    if (aer_last) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = SCAN;
                    end
                end else begin
                    state_nxt_s = SCAN;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                pending_nxt_s = {NEURON_NUM{1'b0}};
            end
        endcase
    end

    // FSM state, pending spikes and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            pending_r   <= {NEURON_NUM{1'b0}};
            aer_valid   <= 1'b0;
            aer_last    <= 1'b0;
            aer_addr    <= {ADDR_W{1'b0}};
            busy        <= 1'b0;
            frame_ready <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            pending_r   <= pending_nxt_s;
            aer_valid   <= any_s;
            aer_last    <= single_s;
            aer_addr    <= idx_s;
            busy        <= any_s;
            frame_ready <= ~any_s;
        end
    end

`ifdef SPIKE_AER_COUNT_EN
    function automatic logic [ADDR_W:0] popcount(input logic [NEURON_NUM-1:0] v);
        logic [ADDR_W:0] cnt;
        cnt = {(ADDR_W+1){1'b0}};
        for (int i = 0; i < NEURON_NUM; i++) begin
            cnt = cnt + {{ADDR_W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    // Spike count of the most recently captured frame, held until the next capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_spike_cnt <= {(ADDR_W+1){1'b0}};
        end else if (capture_s) begin
            frame_spike_cnt <= popcount(spike_in);
        end else begin
            frame_spike_cnt <= frame_spike_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed, table-driven bench for spike_aer_encoder (NEURON_NUM = 64).
module tb_spike_aer_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic [63:0] spike_in = 64'h0;
    logic        frame_valid = 1'b0;
    logic        frame_ready;
    logic        aer_valid;
    logic        aer_ready = 1'b0;
    logic [5:0]  aer_addr;
    logic        aer_last;
    logic        busy;
`ifdef SPIKE_AER_COUNT_EN
    logic [6:0]  frame_spike_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    spike_aer_encoder #(.NEURON_NUM(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .spike_in    (spike_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .aer_valid   (aer_valid),
        .aer_ready   (aer_ready),
        .aer_addr    (aer_addr),
        .aer_last    (aer_last),
`ifdef SPIKE_AER_COUNT_EN
        .frame_spike_cnt (frame_spike_cnt),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] frame;
        int          n_beats;
        int          first_a;
        int          last_a;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " aer_valid"}, {63'd0, aer_valid}, 64'd0);
        check({tag, " frame_ready"}, {63'd0, frame_ready}, 64'd1);
        check({tag, " busy"}, {63'd0, busy}, 64'd0);
    endtask

    // Capture one frame with aer_ready held high and check every beat.
    task automatic run_frame(input logic [63:0] f, input int n, input int first_a, input int last_a);
        logic [63:0] rem;
        int          a;
        bit          found;
        spike_in    = f;
        frame_valid = 1'b1;
        ce          = 1'b1;
        aer_ready   = 1'b1;
        tick();
        frame_valid = 1'b0;
        spike_in    = 64'h0;
`ifdef SPIKE_AER_COUNT_EN
        check("spike_cnt", {57'd0, frame_spike_cnt}, 64'(n));
`endif
        rem = f;
        for (int k = 0; k < n; k++) begin
            a = 0;
            found = 1'b0;
            for (int i = 0; i < 64; i++) begin
                if (!found && rem[i]) begin
                    a = i;
                    found = 1'b1;
                end
            end
            if (k == 0) a = first_a;
            if (k == n - 1) a = last_a;
            check("beat valid", {63'd0, aer_valid}, 64'd1);
            check("beat addr", {58'd0, aer_addr}, 64'(a));
            check("beat last", {63'd0, aer_last}, (k == n - 1) ? 64'd1 : 64'd0);
            check("beat busy", {63'd0, busy}, 64'd1);
            rem[a] = 1'b0;
            tick();
        end
        check_idle("after frame");
    endtask

    initial begin
        vecs[0] = '{64'h91, 3, 0, 7};
        vecs[1] = '{64'h0, 0, 0, 0};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64, 0, 63};
        vecs[3] = '{64'h8000_0000_0000_0001, 2, 0, 63};
        vecs[4] = '{64'h2, 1, 1, 1};
        vecs[5] = '{64'hA000_0000_0000_0100, 3, 8, 63};

        // Reset held for two cycles.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_idle("reset");
        check("reset last", {63'd0, aer_last}, 64'd0);
        check("reset addr", {58'd0, aer_addr}, 64'd0);
`ifdef SPIKE_AER_COUNT_EN
        check("reset cnt", {57'd0, frame_spike_cnt}, 64'd0);
`endif

        // aer_ready while idle must not disturb anything.
        aer_ready = 1'b1;
        tick();
        check_idle("idle ready");

        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].frame, vecs[v].n_beats, vecs[v].first_a, vecs[v].last_a);
        end

        // Backpressure: address 0 held for four cycles, then 63 with last.
        spike_in    = 64'h8000_0000_0000_0001;
        frame_valid = 1'b1;
        ce          = 1'b1;
        aer_ready   = 1'b0;
        tick();
        frame_valid = 1'b0;
        spike_in    = 64'h0;
        for (int k = 0; k < 4; k++) begin
            check("stall valid", {63'd0, aer_valid}, 64'd1);
            check("stall addr", {58'd0, aer_addr}, 64'd0);
            check("stall last", {63'd0, aer_last}, 64'd0);
            check("stall frame_ready", {63'd0, frame_ready}, 64'd0);
            if (k == 3) aer_ready = 1'b1;
            tick();
        end
        check("bp second valid", {63'd0, aer_valid}, 64'd1);
        check("bp second addr", {58'd0, aer_addr}, 64'd63);
        check("bp second last", {63'd0, aer_last}, 64'd1);
        tick();
        check_idle("bp done");

        // ce gating: frame 2 offered with ce low is not captured.
        spike_in    = 64'h2;
        frame_valid = 1'b1;
        ce          = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_idle("ce low");
        end
        ce = 1'b1;
        tick();
        frame_valid = 1'b0;
        spike_in    = 64'h0;
        check("ce addr", {58'd0, aer_addr}, 64'd1);
        check("ce last", {63'd0, aer_last}, 64'd1);
        check("ce valid", {63'd0, aer_valid}, 64'd1);
        tick();
        check_idle("ce done");

        // frame_valid is ignored while a frame drains.
        spike_in    = 64'h6;
        frame_valid = 1'b1;
        tick();
        spike_in    = 64'h1;
        check("scan addr1", {58'd0, aer_addr}, 64'd1);
        tick();
        check("scan addr2", {58'd0, aer_addr}, 64'd2);
        check("scan last2", {63'd0, aer_last}, 64'd1);
        frame_valid = 1'b0;
        spike_in    = 64'h0;
        tick();
        check_idle("scan ignore done");

        // Reset mid-SCAN discards the remainder of frame F0.
        spike_in    = 64'hF0;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        spike_in    = 64'h0;
        check("mid addr4", {58'd0, aer_addr}, 64'd4);
        tick();
        check("mid addr5", {58'd0, aer_addr}, 64'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("mid reset");
        check("mid reset last", {63'd0, aer_last}, 64'd0);
        tick();
        check_idle("mid reset hold");
        run_frame(64'h1, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spike_aer_encoder.md
Name: spike_aer_encoder

Overview:
- Converts the parallel spike vector produced by a neuron layer into a serial address-event (AER) stream: one beat per spiking neuron.
- Sits between the layer's spike output and the off-chip or next-layer event link.
- Captures one frame per handshake and emits addresses lowest-index-first over a valid/ready interface.

Parameters:
NEURON_NUM, 64, width of the spike vector and number of addressable neurons (>=2)
ADDR_W, $clog2(NEURON_NUM), derived localparam, event address width; not overridable

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
ce  input  1  clock enable; gates frame capture only
spike_in  input  NEURON_NUM  spike vector, bit i = neuron i fired this timestep
frame_valid  input  1  spike_in holds a complete frame
frame_ready  output  1  encoder can capture a frame
aer_valid  output  1  aer_addr/aer_last hold a valid event
aer_ready  input  1  downstream accepts the event
aer_addr  output  ADDR_W  index of spiking neuron
aer_last  output  1  final event of the current frame
busy  output  1  high while a frame is being drained

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, pending=0. Next cycle: aer_valid=0, aer_last=0, aer_addr=0, busy=0, frame_ready=1. Reset overrides all other events, including mid-SCAN; any partially drained frame is discarded with no aer_last.
- pending: NEURON_NUM-bit register holding the not-yet-sent spikes.
- IDLE:
  - frame_ready=1, aer_valid=0, busy=0.
  - Capture condition: frame_valid & ce at an edge.
    - spike_in != 0: pending<=spike_in, go to SCAN.
    - spike_in == 0: frame consumed, stay in IDLE, no event emitted.
  - frame_valid while ce=0: not captured. Upstream holds the frame.
- SCAN:
  - frame_ready=0, busy=1, aer_valid=1.
  - aer_addr = index of the lowest set bit of pending.
  - aer_last = 1 when pending has exactly one bit set.
  - Both are decoded from registered state only; there is no combinational path from any input to any output.
  - On aer_valid & aer_ready: clear that bit in pending. If aer_last, go to IDLE.
  - Under stall (aer_ready=0), aer_addr and aer_last stay stable.
  - frame_valid is ignored in SCAN.
- Latency and throughput:
  - Frame captured at edge T gives its first event valid in cycle T+1.
  - One event per cycle under continuous aer_ready.
  - A frame with N spikes occupies N cycles of SCAN plus 1 IDLE cycle before the next capture.
- Ordering: strictly ascending address within a frame. Exactly one aer_last per non-empty frame.
- Boundaries:
  - Bit NEURON_NUM-1 gives aer_addr=NEURON_NUM-1.
  - All bits set gives NEURON_NUM beats, with aer_last on the final beat.
  - aer_ready high while aer_valid=0 has no effect.

Optional Feature:
- Macro: SPIKE_AER_COUNT_EN
- Defined:
  - Adds output frame_spike_cnt [ADDR_W:0], a popcount of the captured frame.
  - Registered at the capture edge; the empty-frame capture writes 0.
  - Reset value is 0.
  - Holds its value until the next capture.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package snn_aer_pkg:
  - state enum {IDLE, SCAN};
  - constant function for address width.
- Sub-module lsb_priority_enc: combinational, parameter N. Inputs: vector. Outputs:
  - index of the lowest set bit;
  - any-set flag;
  - single-bit flag, computed as (v & (v-1)) == 0 && v != 0.
- The FSM and pending register stay in spike_aer_encoder.

Test Plan:
- Reset: rst=1 for 2 cycles, then low -> aer_valid=0, frame_ready=1, busy=0. With SPIKE_AER_COUNT_EN defined, frame_spike_cnt=0.
- Basic frame: spike_in=64'h91, frame_valid=1, ce=1, aer_ready=1 -> aer_addr 0, 4, 7 on consecutive cycles; aer_last only on 7; frame_ready=1 in the following cycle. frame_spike_cnt=3 if enabled.
- Backpressure: spike_in=64'h8000_0000_0000_0001, aer_ready low for 3 cycles after first valid -> addr 0 held stable for 4 cycles; then 63 with aer_last; no beat lost or duplicated.
- Empty frame and ce gating:
  - spike_in=0 captured -> no aer_valid, frame_ready stays 1.
  - Frame 64'h2 with ce=0 -> not captured; after ce=1 -> single event addr 1, aer_last=1.
- Full frame: spike_in=all ones -> 64 beats, addr 0..63, aer_last only on 63, then IDLE.
- Reset mid-SCAN: frame 64'hF0, rst pulsed after addr 4 accepted -> next cycle aer_valid=0; new frame 64'h1 then yields a single addr 0 event with aer_last=1.
